hilo_muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for the HI/LO resource of the MIPS-lite core.
- Executes MULTU and DIVU iteratively, services MTHI/MTLO/MFHI/MFLO, and owns the HI and LO registers.
- Holds the EX stage with a stall while an operation is in flight.
- Sits beside the ALU in EX; the op code comes from the ALU control decode of the instruction func field.

---
 rtl/hilo_muldiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   HI/LO resource sequencer for the MIPS-lite EX stage. It runs MULTU
//   (shift-add, LSB first) and DIVU (restoring, MSB first) one bit per
//   cycle, services MTHI/MTLO/MFHI/MFLO, and owns the HI and LO registers.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   op_valid     EX presents a HI/LO-class instruction this cycle
//   op_code      0 MULTU, 1 DIVU, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO, 6/7 no-op
//   rs_val       multiplicand / dividend / MT source
//   rt_val       multiplier / divisor
//   flush        cancels an in-flight op; blocks acceptance when idle
//   stall        op_valid while busy (combinational)
//   busy         multiply or divide in progress (registered)
//   hilo_rdata   HI for MFHI, LO for MFLO, otherwise 0 (combinational)
//   hi, lo       architectural HI/LO registers
//   div_zero     sticky divide-by-zero flag, cleared by next MULTU/DIVU
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_DIVU  = 3'd1,
    OP_MTHI  = 3'd2,
    OP_MTLO  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5
  } op_e;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo;      // dividend bits shift out MSB first, quotient bits shift in
  logic [WIDTH-1:0]   rem;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign busy   = (state != S_IDLE);
  assign stall  = op_valid && busy;
  assign accept = op_valid && !busy && !flush;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // Multiply step: conditionally add multiplicand into the upper half, then
  // shift the whole accumulator right one place (carry enters at the top).
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step. The remainder is always below the divisor, so
  // only the shifted trial value needs the extra bit; the stored remainder
  // fits in WIDTH bits. A zero divisor always subtracts, giving all-ones/rs.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, divisor};
  assign div_ok    = !div_trial[WIDTH];
  assign rem_nxt   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_nxt   = {quo[WIDTH-2:0], div_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && op_code == OP_MULTU)     state_nxt = S_MUL;
        else if (accept && op_code == OP_DIVU) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush || last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op_code)
              OP_MULTU: begin
                acc      <= {{WIDTH{1'b0}}, rt_val};
                mcand    <= rs_val;
                cnt      <= '0;
                div_zero <= 1'b0;
              end
              OP_DIVU: begin
                quo      <= rs_val;
                divisor  <= rt_val;
                rem      <= '0;
                cnt      <= '0;
                div_zero <= 1'b0;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!flush) begin
            acc <= mul_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) {hi, lo} <= mul_nxt;
          end
        end
        S_DIV: begin
          if (!flush) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == '0) div_zero <= (divisor == '0);
            if (last) begin
              hi <= rem_nxt;
              lo <= quo_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hilo_rdata = '0;
    if (op_code == OP_MFHI)      hilo_rdata = hi;
    else if (op_code == OP_MFLO) hilo_rdata = lo;
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = 3'd0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         flush = 1'b0;
  logic         stall, busy, div_zero;
  logic [W-1:0] hilo_rdata, hi, lo;

  hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .busy(busy), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  // reference architectural state
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_nonempty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
  endtask

  // Issue MULTU (code 0) or DIVU (code 1); flush_at>0 raises flush during
  // that busy cycle so the following edge cancels the operation.
  task automatic issue_long(input logic [2:0] code, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int flush_at);
    int n;
    logic [63:0] p;
    @(posedge clk); #1;
    op_valid = 1'b1;
    op_code  = code;
    rs_val   = a;
    rt_val   = b;
    sb_push("busy_cycles", (flush_at != 0) ? 64'(flush_at) : 64'(W));
    if (flush_at == 0) begin
      if (code == 3'd0) begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end else if (b == '0) begin
        m_lo = '1;
        m_hi = a;
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end
    m_dz = (code == 3'd1) && (b == '0);
    sb_push("hi", 64'(m_hi));
    sb_push("lo", 64'(m_lo));
    sb_push("div_zero", 64'(m_dz));
    @(posedge clk); #1;
    op_valid = 1'b0;
    rs_val   = $urandom;
    rt_val   = $urandom;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 2 && code == 3'd1) check_eq("div_zero_early", 64'(div_zero), 64'(b == '0));
      if (n == flush_at) flush = 1'b1;
      if (n > 100) break;
    end
    flush = 1'b0;
    sb_pop(64'(n));
    sb_pop(64'(hi));
    sb_pop(64'(lo));
    sb_pop(64'(div_zero));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    // reset state
    op_code = 3'd4;
    #12;
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_div_zero", 64'(div_zero), 64'd0);
    check_eq("rst_rdata", 64'(hilo_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op_code = 3'd0;

    issue_long(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue_long(3'd1, 32'd100, 32'd7, 0);
    issue_long(3'd1, 32'h1234, 32'd0, 0);
    ra = $urandom;
    rb = $urandom;
    issue_long(3'd0, ra, rb, 0);
    ra = $urandom;
    rb = $urandom_range(1, 65535);
    issue_long(3'd1, ra, rb, 0);
    issue_long(3'd1, 32'd5, 32'd9, 0);

    // MTHI / MTLO then MFHI / MFLO
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd2; rs_val = 32'hA5A5_A5A5;
    sb_push("mfhi_rdata", 64'h0000_0000_A5A5_A5A5);
    @(negedge clk); check_eq("stall_mthi", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_code = 3'd3; rs_val = 32'h5A5A_5A5A;
    sb_push("mflo_rdata", 64'h0000_0000_5A5A_5A5A);
    @(negedge clk); check_eq("stall_mtlo", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_code = 3'd4; rs_val = $urandom;
    @(negedge clk); check_eq("stall_mfhi", 64'(stall), 64'd0);
    sb_pop(64'(hilo_rdata));
    @(posedge clk); #1;
    op_code = 3'd5;
    @(negedge clk); check_eq("stall_mflo", 64'(stall), 64'd0);
    sb_pop(64'(hilo_rdata));
    @(posedge clk); #1;
    op_valid = 1'b0;
    m_hi = 32'hA5A5_A5A5;
    m_lo = 32'h5A5A_5A5A;

    // MULTU 3*5 followed by a held MFLO
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd0; rs_val = 32'd3; rt_val = 32'd5;
    m_hi = '0; m_lo = 32'd15; m_dz = 1'b0;
    sb_push("stall_cycles", 64'd32);
    sb_push("mflo_after_mul", 64'd15);
    @(posedge clk); #1;
    op_code = 3'd5; rs_val = $urandom; rt_val = $urandom;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 100) break;
    end
    sb_pop(64'(n));
    sb_pop(64'(hilo_rdata));
    check_eq("busy_after_mul", 64'(busy), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;

    // reserved op code while idle
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd6; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("rsvd_stall", 64'(stall), 64'd0);
    check_eq("rsvd_rdata", 64'(hilo_rdata), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check_eq("rsvd_hi", 64'(hi), 64'(m_hi));
    check_eq("rsvd_lo", 64'(lo), 64'(m_lo));
    check_eq("rsvd_busy", 64'(busy), 64'd0);

    // flush while idle blocks MTHI and MULTU
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd2; rs_val = 32'h1357_9BDF; flush = 1'b1;
    @(posedge clk); #1;
    op_code = 3'd0; rs_val = 32'd2; rt_val = 32'd2;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_hi", 64'(hi), 64'(m_hi));
    check_eq("idle_flush_busy", 64'(busy), 64'd0);

    // flush mid-operation and on the completion edge
    do_reset();
    issue_long(3'd0, 32'd6, 32'd7, 10);
    issue_long(3'd0, 32'd6, 32'd7, 32);
    issue_long(3'd1, 32'd77, 32'd0, 10);
    issue_long(3'd0, 32'd6, 32'd7, 0);

    // reset during an in-flight divide by zero
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd1000; rt_val = 32'd0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("pre_rst_div_zero", 64'(div_zero), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_hi", 64'(hi), 64'd0);
    check_eq("mid_rst_lo", 64'(lo), 64'd0);
    check_eq("mid_rst_div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    issue_long(3'd1, 32'd9, 32'd3, 0);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
